// File: rtl/dac_serial_multicanal_if.sv
// Parallel sample side and serial DAC pin side of the multi-channel DAC transmitter.
interface dac_serial_multicanal_if #(
  parameter int DATA_W = 12,
  parameter int CH_N   = 2
);
  logic [CH_N*DATA_W-1:0] Data_In;
  logic [CH_N-1:0]        Ch_En;
  logic                   Rx_Listo;
  logic                   Busy;
  logic                   Done;
  logic                   Overrun;
  logic                   Sclk;
  logic                   Sync;
  logic                   Data_Out;

  // Sample producer (filter/equaliser side).
  modport master (
    output Data_In, Ch_En, Rx_Listo,
    input  Busy, Done, Overrun, Sclk, Sync, Data_Out
  );

  // Transmitter.
  modport slave (
    input  Data_In, Ch_En, Rx_Listo,
    output Busy, Done, Overrun, Sclk, Sync, Data_Out
  );
endinterface

// File: rtl/dac_serial_multicanal.sv
// Multi-channel serial DAC transmitter: latches one sample per channel on a
// strobe, then sends each enabled channel as a Sync-framed word, MSB first,
// on a serial clock divided down from Clk.
module dac_serial_multicanal #(
  parameter int DATA_W   = 12,
  parameter int CH_N     = 2,
  parameter int CH_IDX_W = 2,
  parameter int FRAME_W  = 16,
  parameter int CLK_DIV  = 4,
  parameter int GAP_CYC  = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  dac_serial_multicanal_if.slave   bus
);

  localparam int IDX_W = $clog2(CH_N + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_W + 1);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t                 state, next_state;
  logic [CH_N*DATA_W-1:0] buf_data;
  logic [CH_N-1:0]        buf_en;
  logic [IDX_W-1:0]       ch_idx;
  logic                   scan_hit;
  logic [IDX_W-1:0]       scan_ch;
  logic [FRAME_W-1:0]     frame;
  logic [FRAME_W-1:0]     shreg;
  logic [DIV_W-1:0]       div_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   sclk_r, sync_r, data_out_r, overrun_r;
  logic                   div_wrap, last_rise, gap_end;

  assign div_wrap  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_rise = div_wrap && !sclk_r && (bit_cnt == BIT_W'(FRAME_W));
  assign gap_end   = (gap_cnt == GAP_W'(GAP_CYC - 1));

  // Lowest enabled channel at or above the current index, and its frame word.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
    scan_hit = 1'b0;
    scan_ch  = '0;
    for (int k = CH_N - 1; k >= 0; k--) begin
      if (buf_en[k] && (k >= int'(ch_idx))) begin
        scan_hit = 1'b1;
        scan_ch  = IDX_W'(k);
      end
    end
    frame = FRAME_W'({CH_IDX_W'(scan_ch), buf_data[scan_ch*DATA_W +: DATA_W]});
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (bus.Rx_Listo) next_state = S_SCAN;
      S_SCAN:  next_state = scan_hit ? S_SHIFT : S_DONE;
      S_SHIFT: if (last_rise) next_state = S_GAP;
      S_GAP:   if (gap_end) next_state = S_SCAN;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // FSM outputs: Busy covers everything from accept through the Done cycle.
  always_comb begin
    bus.Busy = (state != S_IDLE);
    bus.Done = (state == S_DONE);
  end

  // Sample holding buffer, loaded only on accept.
  always_ff @(posedge Clk) begin
    // NOTE: the data buffer has no reset; it is always written on accept before it is read.
    if (state == S_IDLE && bus.Rx_Listo) begin
      buf_data <= bus.Data_In;
      buf_en   <= bus.Ch_En;
    end
  end

  // Serial datapath: divider, bit/gap counters, shift register and pin registers.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ch_idx     <= '0;
      shreg      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sclk_r     <= 1'b1;
      sync_r     <= 1'b1;
      data_out_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      overrun_r <= bus.Rx_Listo && (state != S_IDLE);
      unique case (state)
        S_IDLE: if (bus.Rx_Listo) ch_idx <= '0;
        S_SCAN: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          gap_cnt <= '0;
          if (scan_hit) begin
            ch_idx     <= scan_ch;
            shreg      <= frame;
            data_out_r <= frame[FRAME_W-1];
            sync_r     <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (div_wrap) begin
            div_cnt <= '0;
            if (sclk_r) begin
              // Falling edge: the DAC samples the current bit.
              sclk_r  <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
            end else if (last_rise) begin
              sclk_r     <= 1'b1;
              sync_r     <= 1'b1;
              data_out_r <= 1'b0;
            end else begin
              // Rising edge: present the next bit.
              sclk_r     <= 1'b1;
              shreg      <= {shreg[FRAME_W-2:0], 1'b0};
              data_out_r <= shreg[FRAME_W-2];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_end) ch_idx <= ch_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Sclk     = sclk_r;
  assign bus.Sync     = sync_r;
  assign bus.Data_Out = data_out_r;
  assign bus.Overrun  = overrun_r;

endmodule

// File: tb/tb_dac_serial_multicanal.sv
// Directed bench for dac_serial_multicanal: default 2-channel instance (a)
// and a fast 4-channel instance (b) with CLK_DIV=1, GAP_CYC=1.
module tb_dac_serial_multicanal;

  typedef struct {
    logic [15:0] word;
    int          low;
    int          bits;
  } frame_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dac_serial_multicanal_if #(.DATA_W(12), .CH_N(2)) ifa ();
  dac_serial_multicanal_if #(.DATA_W(12), .CH_N(4)) ifb ();

  dac_serial_multicanal dut_a (.Clk(clk), .Rst(rst_a), .bus(ifa));

  dac_serial_multicanal #(
    .DATA_W(12), .CH_N(4), .CH_IDX_W(2), .FRAME_W(16), .CLK_DIV(1), .GAP_CYC(1)
  ) dut_b (.Clk(clk), .Rst(rst_b), .bus(ifb));

  // Frame monitors: sample on the falling Clk edge, shift in Data_Out on each
  // falling Sclk while Sync is low, and log the word when Sync returns high.
  frame_t      fr_a[$], fr_b[$];
  logic [15:0] sh_a, sh_b;
  int          nb_a, nb_b, low_a, low_b;
  logic        ps_a, ps_b, pk_a, pk_b;
  int          viol_a = 0, viol_b = 0, act_a = 0, ovr_a = 0;

  always @(negedge clk) begin
    if (!rst_a) begin
      sh_a = '0; nb_a = 0; low_a = 0; ps_a = 1'b1; pk_a = 1'b1;
    end else begin
      if (ifa.Sync && ifa.Data_Out) viol_a++;
      if (!ifa.Sync || !ifa.Sclk) act_a++;
      if (ifa.Overrun) ovr_a++;
      if (!ifa.Sync) begin
        low_a++;
        if (pk_a && !ifa.Sclk) begin
          sh_a = {sh_a[14:0], ifa.Data_Out};
          nb_a++;
        end
      end
      if (ifa.Sync && !ps_a) begin
        fr_a.push_back('{sh_a, low_a, nb_a});
        sh_a = '0; nb_a = 0; low_a = 0;
      end
      ps_a = ifa.Sync;
      pk_a = ifa.Sclk;
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      sh_b = '0; nb_b = 0; low_b = 0; ps_b = 1'b1; pk_b = 1'b1;
    end else begin
      if (ifb.Sync && ifb.Data_Out) viol_b++;
      if (!ifb.Sync) begin
        low_b++;
        if (pk_b && !ifb.Sclk) begin
          sh_b = {sh_b[14:0], ifb.Data_Out};
          nb_b++;
        end
      end
      if (ifb.Sync && !ps_b) begin
        fr_b.push_back('{sh_b, low_b, nb_b});
        sh_b = '0; nb_b = 0; low_b = 0;
      end
      ps_b = ifb.Sync;
      pk_b = ifb.Sclk;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame_a(input string tag, input int i, input logic [15:0] w, input int low);
    if (i < fr_a.size()) begin
      check($sformatf("%s_word%0d", tag, i), fr_a[i].word, w);
      check($sformatf("%s_low%0d", tag, i), fr_a[i].low, low);
      check($sformatf("%s_bits%0d", tag, i), fr_a[i].bits, 16);
    end else begin
      check($sformatf("%s_missing%0d", tag, i), fr_a.size(), i + 1);
    end
  endtask

  task automatic check_frame_b(input string tag, input int i, input logic [15:0] w, input int low);
    if (i < fr_b.size()) begin
      check($sformatf("%s_word%0d", tag, i), fr_b[i].word, w);
      check($sformatf("%s_low%0d", tag, i), fr_b[i].low, low);
      check($sformatf("%s_bits%0d", tag, i), fr_b[i].bits, 16);
    end else begin
      check($sformatf("%s_missing%0d", tag, i), fr_b.size(), i + 1);
    end
  endtask

  // One-cycle strobe; returns #1 after the edge that samples it.
  task automatic strobe_a(input logic [23:0] d, input logic [1:0] en);
    @(posedge clk); #1;
    ifa.Data_In = d; ifa.Ch_En = en; ifa.Rx_Listo = 1'b1;
    @(posedge clk); #1;
    ifa.Rx_Listo = 1'b0;
  endtask

  task automatic strobe_b(input logic [47:0] d, input logic [3:0] en);
    @(posedge clk); #1;
    ifb.Data_In = d; ifb.Ch_En = en; ifb.Rx_Listo = 1'b1;
    @(posedge clk); #1;
    ifb.Rx_Listo = 1'b0;
  endtask

  // Counts cycles from the strobe until Done is seen; bounded.
  task automatic wait_done_a(output int lat);
    lat = 1;
    while (ifa.Done !== 1'b1 && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_done_b(output int lat);
    lat = 1;
    while (ifb.Done !== 1'b1 && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat;
  int act0;

  initial begin
    ifa.Data_In = '0; ifa.Ch_En = '0; ifa.Rx_Listo = 1'b0;
    ifb.Data_In = '0; ifb.Ch_En = '0; ifb.Rx_Listo = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", ifa.Sclk, 1);
    check("rst_sync", ifa.Sync, 1);
    check("rst_dout", ifa.Data_Out, 0);
    check("rst_busy", ifa.Busy, 0);
    check("rst_done", ifa.Done, 0);
    check("rst_ovr", ifa.Overrun, 0);
    rst_a = 1'b1; rst_b = 1'b1;

    // Both channels, default timing: 1 + 2*(1+128+2) + 1 = 264 cycles.
    fr_a.delete();
    strobe_a({12'h0AB, 12'hFFF}, 2'b11);
    check("t1_busy", ifa.Busy, 1);
    wait_done_a(lat);
    check("t1_latency", lat, 264);
    check("t1_nframes", fr_a.size(), 2);
    check_frame_a("t1", 0, 16'h0FFF, 128);
    check_frame_a("t1", 1, 16'h10AB, 128);
    @(posedge clk); #1;
    check("t1_busy_end", ifa.Busy, 0);
    check("t1_done_end", ifa.Done, 0);
    check("t1_no_ovr", ovr_a, 0);

    // Only channel 1 enabled: 1 + 131 + 1 = 133 cycles.
    fr_a.delete();
    strobe_a({12'h800, 12'h123}, 2'b10);
    wait_done_a(lat);
    check("t2_latency", lat, 133);
    check("t2_nframes", fr_a.size(), 1);
    check_frame_a("t2", 0, 16'h1800, 128);

    // Empty mask: Busy for 2 cycles, Done on the second, no serial activity.
    act0 = act_a;
    strobe_a(24'h5A5A5A, 2'b00);
    check("t3_busy1", ifa.Busy, 1);
    check("t3_done1", ifa.Done, 0);
    @(posedge clk); #1;
    check("t3_busy2", ifa.Busy, 1);
    check("t3_done2", ifa.Done, 1);
    // Strobe during the Done cycle is dropped; held one more cycle it is accepted.
    ifa.Data_In = 24'h000000; ifa.Ch_En = 2'b00; ifa.Rx_Listo = 1'b1;
    @(posedge clk); #1;
    check("t3_ovr_at_done", ifa.Overrun, 1);
    check("t3_idle_busy", ifa.Busy, 0);
    @(posedge clk); #1;
    ifa.Rx_Listo = 1'b0;
    check("t3_reaccept_busy", ifa.Busy, 1);
    check("t3_ovr_clear", ifa.Overrun, 0);
    @(posedge clk); #1;
    check("t3_reaccept_done", ifa.Done, 1);
    @(posedge clk); #1;
    check("t3_busy_end", ifa.Busy, 0);
    check("t3_no_activity", act_a - act0, 0);

    // Strobe mid-frame: Overrun, frames keep the first sample set.
    fr_a.delete();
    strobe_a({12'h456, 12'h789}, 2'b11);
    repeat (20) @(posedge clk);
    strobe_a({12'hAAA, 12'h555}, 2'b01);
    check("t4_ovr", ifa.Overrun, 1);
    check("t4_busy", ifa.Busy, 1);
    @(posedge clk); #1;
    check("t4_ovr_pulse", ifa.Overrun, 0);
    wait_done_a(lat);
    check("t4_done", ifa.Done, 1);
    check("t4_nframes", fr_a.size(), 2);
    check_frame_a("t4", 0, 16'h0789, 128);
    check_frame_a("t4", 1, 16'h1456, 128);

    // Reset during bit 7 of frame 0, then a clean transaction.
    fr_a.delete();
    strobe_a({12'h999, 12'h777}, 2'b11);
    repeat (60) @(posedge clk);
    #1;
    check("t5_mid_frame", ifa.Sync, 0);
    rst_a = 1'b0;
    @(posedge clk); #1;
    check("t5_sync", ifa.Sync, 1);
    check("t5_sclk", ifa.Sclk, 1);
    check("t5_busy", ifa.Busy, 0);
    check("t5_dout", ifa.Data_Out, 0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    check("t5_discarded", fr_a.size(), 0);
    strobe_a({12'h321, 12'hCDE}, 2'b11);
    wait_done_a(lat);
    check("t5_latency", lat, 264);
    check("t5_nframes", fr_a.size(), 2);
    check_frame_a("t5", 0, 16'h0CDE, 128);
    check_frame_a("t5", 1, 16'h1321, 128);
    check("a_dout_idle_zero", viol_a, 0);

    // Fast 4-channel instance: 1 + 4*(1+32+1) + 1 = 138 cycles, back-to-back.
    fr_b.delete();
    strobe_b({12'd3, 12'd2, 12'd1, 12'd0}, 4'hF);
    wait_done_b(lat);
    check("t6_latency1", lat, 138);
    strobe_b({12'd7, 12'd6, 12'd5, 12'd4}, 4'hF);
    check("t6_accept2", ifb.Busy, 1);
    wait_done_b(lat);
    check("t6_latency2", lat, 138);
    check("t6_nframes", fr_b.size(), 8);
    check_frame_b("t6", 0, 16'h0000, 32);
    check_frame_b("t6", 1, 16'h1001, 32);
    check_frame_b("t6", 2, 16'h2002, 32);
    check_frame_b("t6", 3, 16'h3003, 32);
    check_frame_b("t6", 4, 16'h0004, 32);
    check_frame_b("t6", 5, 16'h1005, 32);
    check_frame_b("t6", 6, 16'h2006, 32);
    check_frame_b("t6", 7, 16'h3007, 32);
    check("b_dout_idle_zero", viol_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
